// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FP16 FIR per-sample MAC sequencer.
package fir_seq_pkg;

    localparam int unsigned DEF_NTAPS   = 64;
    localparam int unsigned DEF_AW      = 6;
    localparam int unsigned DEF_MAC_LAT = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        MAC,
        DRAIN,
        DONE
    } state_t;

    // Ring index (a - b) mod n; n must be a power of two and b < n.
    function automatic int unsigned ring_sub(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        return (a + n - b) & (n - 1);
    endfunction

endpackage

// File: rtl/fir_slow_edge.sv
// Rising-edge detector for the slow sample clock, sampled as data in the fast domain.
module fir_slow_edge (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic clk_slow,
    input  logic valid_in,
    output logic rise
);

    logic clk_slow_q;

    // Resets high so a slow clock already high at reset release is not an edge.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            clk_slow_q <= 1'b1;
        end else begin
            clk_slow_q <= clk_slow;
        end
    end

    assign rise = clk_slow & ~clk_slow_q & valid_in;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Per-sample controller: delay-line write, MAC tap sweep, pipeline drain, output latch,
// and coefficient-RAM port arbitration.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned NTAPS   = DEF_NTAPS,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned MAC_LAT = DEF_MAC_LAT
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          clk_slow,
    input  logic          valid_in,
    input  logic          cload,
    input  logic [AW-1:0] caddr,
    output logic          cack,
    output logic          coef_we,
    output logic [AW-1:0] tap_addr,
    output logic          din_we,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] data_raddr,
    output logic          acc_clr,
    output logic          mac_en,
    output logic          dout_latch,
    output logic          busy,
    output logic          overrun
);

    state_t        state, state_nxt;
    logic [AW-1:0] k, k_nxt;
    logic [AW-1:0] newest, newest_nxt;
    logic [AW-1:0] wptr_nxt;
    logic          pend, pend_nxt;
    logic          overrun_nxt;
    logic          rise;

    logic          cack_d, coef_we_d, din_we_d, acc_clr_d, mac_en_d, dout_latch_d, busy_d;
    logic [AW-1:0] tap_addr_d, data_raddr_d;

    fir_slow_edge u_edge (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .clk_slow (clk_slow),
        .valid_in (valid_in),
        .rise     (rise)
    );

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        newest_nxt  = newest;
        wptr_nxt    = wptr;
        pend_nxt    = pend;
        overrun_nxt = overrun;

        if (rise) begin
            if ((state == IDLE || state == LOAD) && !pend) begin
                pend_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                // An edge arriving alongside cload is treated as already pending, so the
                // sample write wins and the load waits until the pass completes.
                if (pend) begin
                    state_nxt = WRITE;
                    pend_nxt  = 1'b0;
                end else if (cload && !rise) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = IDLE;
            WRITE: begin
                newest_nxt = wptr;
                wptr_nxt   = wptr + 1'b1;
                k_nxt      = '0;
                state_nxt  = MAC;
            end
            MAC: begin
                if (k == AW'(NTAPS - 1)) begin
                    k_nxt     = '0;
                    state_nxt = DRAIN;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            DRAIN: begin
                if (k == AW'(MAC_LAT - 1)) begin
                    k_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state.
    always_comb begin
        cack_d       = 1'b0;
        coef_we_d    = 1'b0;
        din_we_d     = 1'b0;
        acc_clr_d    = 1'b0;
        mac_en_d     = 1'b0;
        dout_latch_d = 1'b0;
        tap_addr_d   = '0;
        data_raddr_d = '0;
        busy_d       = (state_nxt != IDLE);
        case (state_nxt)
            LOAD: begin
                cack_d     = 1'b1;
                coef_we_d  = 1'b1;
                tap_addr_d = caddr;
            end
            WRITE: din_we_d = 1'b1;
            MAC: begin
                mac_en_d     = 1'b1;
                acc_clr_d    = (k_nxt == '0);
                tap_addr_d   = k_nxt;
                data_raddr_d = AW'(ring_sub(32'(newest_nxt), 32'(k_nxt), NTAPS));
            end
            DONE:    dout_latch_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            newest     <= '0;
            wptr       <= '0;
            pend       <= 1'b0;
            overrun    <= 1'b0;
            cack       <= 1'b0;
            coef_we    <= 1'b0;
            tap_addr   <= '0;
            din_we     <= 1'b0;
            data_raddr <= '0;
            acc_clr    <= 1'b0;
            mac_en     <= 1'b0;
            dout_latch <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            newest     <= newest_nxt;
            wptr       <= wptr_nxt;
            pend       <= pend_nxt;
            overrun    <= overrun_nxt;
            cack       <= cack_d;
            coef_we    <= coef_we_d;
            tap_addr   <= tap_addr_d;
            din_we     <= din_we_d;
            data_raddr <= data_raddr_d;
            acc_clr    <= acc_clr_d;
            mac_en     <= mac_en_d;
            dout_latch <= dout_latch_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: each scenario pushes cycle-stamped expected strobe events; a monitor pops them.
module tb_fir_mac_sequencer;

    localparam int unsigned NT = 64;

    typedef struct packed {
        logic [31:0] cyc;
        logic        din_we;
        logic        mac_en;
        logic        acc_clr;
        logic        dout_latch;
        logic        coef_we;
        logic        cack;
        logic [5:0]  wptr;
        logic [5:0]  tap_addr;
        logic [5:0]  data_raddr;
    } ev_t;

    logic       clk_fast = 1'b0;
    logic       rst_n;
    logic       clk_slow;
    logic       valid_in;
    logic       cload;
    logic [5:0] caddr;
    logic       cack, coef_we, din_we, acc_clr, mac_en, dout_latch, busy, overrun;
    logic [5:0] tap_addr, wptr, data_raddr;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    ev_t         q[$];
    logic [5:0]  model_wptr = '0;

    fir_mac_sequencer #(.NTAPS(64), .AW(6), .MAC_LAT(3)) dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .clk_slow   (clk_slow),
        .valid_in   (valid_in),
        .cload      (cload),
        .caddr      (caddr),
        .cack       (cack),
        .coef_we    (coef_we),
        .tap_addr   (tap_addr),
        .din_we     (din_we),
        .wptr       (wptr),
        .data_raddr (data_raddr),
        .acc_clr    (acc_clr),
        .mac_en     (mac_en),
        .dout_latch (dout_latch),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk_fast = ~clk_fast;
    always @(posedge clk_fast) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    function automatic ev_t ev_at(input int unsigned c, input logic [5:0] w);
        ev_t e;
        e      = '0;
        e.cyc  = c;
        e.wptr = w;
        return e;
    endfunction

    // Full expected pass for a sample whose edge is seen in cycle t.
    task automatic push_pass(input int unsigned t);
        ev_t        e;
        logic [5:0] w;
        logic [5:0] kk;
        w        = model_wptr;
        e        = ev_at(t + 2, w);
        e.din_we = 1'b1;
        q.push_back(e);
        for (int k = 0; k < NT; k++) begin
            kk           = 6'(k);
            e            = ev_at(t + 3 + k, w + 6'd1);
            e.mac_en     = 1'b1;
            e.acc_clr    = (k == 0);
            e.tap_addr   = kk;
            e.data_raddr = w - kk;
            q.push_back(e);
        end
        e            = ev_at(t + 70, w + 6'd1);
        e.dout_latch = 1'b1;
        q.push_back(e);
        model_wptr = w + 6'd1;
    endtask

    task automatic push_load(input int unsigned c, input logic [5:0] a);
        ev_t e;
        e          = ev_at(c, model_wptr);
        e.coef_we  = 1'b1;
        e.cack     = 1'b1;
        e.tap_addr = a;
        q.push_back(e);
    endtask

    task automatic sample_edge(input logic v, output int unsigned t);
        clk_slow = 1'b1;
        valid_in = v;
        t        = cyc;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: %0d expected events still pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic monitor();
        ev_t act, e;
        forever begin
            @(negedge clk_fast);
            if (rst_n) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL missing_event: expected event at cycle %0d not seen (now %0d)",
                             q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                if (din_we | mac_en | acc_clr | dout_latch | coef_we | cack) begin
                    act            = '0;
                    act.cyc        = cyc;
                    act.din_we     = din_we;
                    act.mac_en     = mac_en;
                    act.acc_clr    = acc_clr;
                    act.dout_latch = dout_latch;
                    act.coef_we    = coef_we;
                    act.cack       = cack;
                    act.wptr       = wptr;
                    act.tap_addr   = tap_addr;
                    act.data_raddr = data_raddr;
                    n_chk++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event: cycle %0d we=%b mac=%b clr=%b latch=%b cwe=%b cack=%b, required no strobes",
                                 cyc, din_we, mac_en, acc_clr, dout_latch, coef_we, cack);
                    end else begin
                        e = q.pop_front();
                        if (act !== e) begin
                            n_err++;
                            $display("FAIL event: got cyc=%0d we=%b mac=%b clr=%b latch=%b cwe=%b cack=%b wptr=%0d tap=%0d raddr=%0d, required cyc=%0d we=%b mac=%b clr=%b latch=%b cwe=%b cack=%b wptr=%0d tap=%0d raddr=%0d",
                                     act.cyc, act.din_we, act.mac_en, act.acc_clr, act.dout_latch, act.coef_we,
                                     act.cack, act.wptr, act.tap_addr, act.data_raddr,
                                     e.cyc, e.din_we, e.mac_en, e.acc_clr, e.dout_latch, e.coef_we,
                                     e.cack, e.wptr, e.tap_addr, e.data_raddr);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [30:0] v;
        v = {cack, coef_we, tap_addr, din_we, wptr, data_raddr, acc_clr, mac_en, dout_latch, busy, overrun};
        n_chk++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL %s: outputs=%h, required all zero", name, v);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_chk++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic test_reset();
        int unsigned t;
        repeat (3) tick();
        check_all_zero("reset_state");
        clk_slow = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_bit("no_pass_after_release_busy", busy, 1'b0);
        clk_slow = 1'b0;
        tick();
        sample_edge(1'b1, t);
        push_pass(t);
        repeat (8) tick();
        clk_slow = 1'b0;
        while (cyc < t + 20) tick();
        check_bit("busy_mid_mac", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_mac");
        q.delete();
        model_wptr = '0;
        clk_slow   = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_bit("no_pass_after_mid_reset", busy, 1'b0);
        n_chk++;
        if (wptr !== 6'd0) begin
            n_err++;
            $display("FAIL wptr_after_reset: got %0d, required 0", wptr);
        end
        clk_slow = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int unsigned t;
        sample_edge(1'b1, t);
        push_pass(t);
        repeat (8) tick();
        clk_slow = 1'b0;
        check_bit("busy_during_pass", busy, 1'b1);
        wait_idle(100);
        repeat (3) tick();
        n_chk++;
        if (wptr !== 6'd1) begin
            n_err++;
            $display("FAIL wptr_after_single: got %0d, required 1", wptr);
        end
        check_bit("idle_after_single", busy, 1'b0);
    endtask

    task automatic test_valid_low();
        int unsigned t;
        logic        seen_busy;
        seen_busy = 1'b0;
        sample_edge(1'b0, t);
        tick();
        valid_in = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (busy) seen_busy = 1'b1;
            if (i == 8) clk_slow = 1'b0;
            tick();
        end
        check_bit("valid_low_busy", seen_busy, 1'b0);
        n_chk++;
        if (wptr !== model_wptr) begin
            n_err++;
            $display("FAIL valid_low_wptr: got %0d, required %0d", wptr, model_wptr);
        end
    endtask

    task automatic test_coef_load();
        logic [5:0] addrs [3];
        int unsigned c;
        addrs = '{6'd5, 6'd0, 6'd63};
        for (int i = 0; i < 3; i++) begin
            caddr = addrs[i];
            cload = 1'b1;
            c     = cyc;
            push_load(c + 1, addrs[i]);
            repeat (2) tick();
            cload = 1'b0;
            repeat (5) tick();
            wait_idle(5);
        end
    endtask

    task automatic test_simultaneous();
        int unsigned t;
        caddr = 6'd9;
        cload = 1'b1;
        sample_edge(1'b1, t);
        push_pass(t);
        push_load(t + 72, 6'd9);
        repeat (8) tick();
        clk_slow = 1'b0;
        while (cyc < t + 73) tick();
        cload = 1'b0;
        repeat (5) tick();
        wait_idle(10);
    endtask

    task automatic test_overrun();
        int unsigned t;
        sample_edge(1'b1, t);
        push_pass(t);
        repeat (8) tick();
        clk_slow = 1'b0;
        while (cyc < t + 20) tick();
        check_bit("overrun_before", overrun, 1'b0);
        clk_slow = 1'b1;
        tick();
        check_bit("overrun_set", overrun, 1'b1);
        repeat (8) tick();
        clk_slow = 1'b0;
        wait_idle(150);
        repeat (5) tick();
        check_bit("overrun_sticky", overrun, 1'b1);
        n_chk++;
        if (wptr !== model_wptr) begin
            n_err++;
            $display("FAIL overrun_wptr: got %0d, required %0d", wptr, model_wptr);
        end
    endtask

    task automatic test_wrap();
        int unsigned t;
        rst_n = 1'b0;
        tick();
        check_all_zero("wrap_reset");
        rst_n      = 1'b1;
        model_wptr = '0;
        tick();
        for (int s = 0; s < 65; s++) begin
            sample_edge(1'b1, t);
            push_pass(t);
            repeat (8) tick();
            clk_slow = 1'b0;
            while (cyc < t + 80) tick();
        end
        wait_idle(100);
        n_chk++;
        if (wptr !== 6'd1) begin
            n_err++;
            $display("FAIL wptr_after_wrap: got %0d, required 1", wptr);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        clk_slow = 1'b0;
        valid_in = 1'b1;
        cload    = 1'b0;
        caddr    = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_valid_low();
        test_coef_load();
        test_simultaneous();
        test_overrun();
        test_wrap();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
